iic_slave_regs: RTL and testbench
=================================

# iic_slave_regs

I2C target (responder) that terminates the two-wire bus driven by the team's I2C master (`iic_drive`). It uses the master's addressing format: a 7-bit device address, a 16-bit register address sent MSB first, then 8-bit data. It oversamples SCL/SDA on the system clock, decodes START/STOP, ACKs its own address, and performs register writes and reads through a simple external register port. It sits in sensor/peripheral models and loopback benches, facing the master's `scl`/`sda` pins.

## Interface
- `DEV_ADDR`, 7'h3C: 7-bit device address this target answers to.
- `clk_8m`  in  1: system clock. All logic is on the rising edge.
- `rst`  in  1: asynchronous, active-high reset.
- `scl`  in  1: I2C clock from the master. The block never stretches the clock.
- `sda`  inout  1: open-drain data line. The block drives `1'b0` or `1'bz`, never `1'b1`.
- `reg_wr_en`  out  1: one-cycle write strobe.
- `reg_rd_en`  out  1: one-cycle read strobe.
- `reg_addr`  out  16: register pointer, valid with either strobe.
- `reg_wdata`  out  8: write data, valid with `reg_wr_en`.
- `reg_rdata`  in  8: read data. Sampled exactly 1 cycle after `reg_rd_en`.
- `busy`  out  1: high from an address match until the next STOP or START.

## Operation
- **Input conditioning.** SCL and SDA each pass through a 2-FF synchronizer followed by a one-register edge detector. `scl_rise`, `scl_fall`, `sda_rise` and `sda_fall` are single-cycle pulses.
- **Bus conditions.** START is `sda_fall` while synced SCL is high. STOP is `sda_rise` while synced SCL is high. Both take priority over everything else in any state.
  - START, including a repeated START: bit counter cleared, go to ADDR. The register pointer is kept.
  - STOP: go to IDLE and release SDA.
- **Bit handling.** Input bits are sampled on `scl_rise`, MSB first, into an 8-bit shift register with a 4-bit counter. Any SDA drive change happens only on `scl_fall`.
- **States.**
  - IDLE: waits for START.
  - ADDR: receives 8 bits. If bits[7:1] equal `DEV_ADDR`, go to ADDR_ACK and latch the R/W bit (bit 0, where 1 means read). Otherwise go to IGNORE.
  - IGNORE: SDA stays released until START or STOP.
  - ADDR_ACK: drives SDA low for the 9th clock.
    - Write: next state is REG_HI.
    - Read: pulse `reg_rd_en` with the current pointer, load `reg_rdata` one cycle later, then go to RD_DATA.
  - REG_HI, then ACK_HI: receive the pointer's high byte and ACK it.
  - REG_LO, then ACK_LO: receive the pointer's low byte and ACK it.
  - WR_DATA, then WR_ACK: on the 8th `scl_rise`, pulse `reg_wr_en` with `reg_addr` = pointer and `reg_wdata` = the byte. ACK, increment the pointer, and loop back to WR_DATA.
  - RD_DATA: shifts the loaded byte onto SDA MSB first. A 1 bit means release, a 0 bit means drive low.
  - RD_ACK: releases SDA and samples the master's bit on the 9th `scl_rise`.
    - ACK (0): increment the pointer, pulse `reg_rd_en`, load the next byte, return to RD_DATA.
    - NACK (1): go to IGNORE.
- **Pointer.** 16-bit, incrementing modulo 2^16, so 0xFFFF wraps to 0x0000.
- **Read pointer source.** A read after a repeated START uses the pointer set by the preceding write phase. This is the combined-format random read.

## Timing
- **Reset values.** `sda` = z, `reg_wr_en` = 0, `reg_rd_en` = 0, `reg_addr` = 0, `reg_wdata` = 0, `busy` = 0, state = IDLE. Synchronizers reset to 1.
- **Reset mid-transfer.** Releases SDA asynchronously. The block then ignores the bus until the next START.
- **Input latency.** 3 `clk_8m` cycles from a pin edge to its internal pulse.
- **Bus timing requirements.** SCL high and low phases must each be at least 8 `clk_8m` cycles. Data hold after SCL falls must be at least 4 cycles.
- **Read data readiness.**
  - `reg_rd_en` is asserted 1 cycle after the `scl_fall` that ends the ACK bit.
  - The byte is loaded 1 cycle after `reg_rd_en`.
  - The first data bit is on SDA 3 cycles after `scl_fall`.
- **ACK drive.** SDA goes low on the `scl_fall` after the 8th bit and is released on the `scl_fall` after the 9th.
- **Write strobe.** `reg_wr_en` fires once per data byte, 1 cycle after the 8th `scl_rise`. It is never issued for address or pointer bytes.
- **Unterminated bytes.** A START or STOP that arrives mid-byte discards the partial byte. No strobe is issued.

## Test plan
- **Single write.** START, 0x78, 0x12, 0x34, 0xA5, STOP → one `reg_wr_en` with `reg_addr` = 0x1234 and `reg_wdata` = 0xA5. Four ACKs observed. `busy` falls after STOP.
- **Random read.** Write pointer 0x1234, repeated START, 0x79, bench memory[0x1234] = 0x5A, master NACK, STOP → SDA carries 0x5A. Exactly one `reg_rd_en` at 0x1234.
- **Address mismatch.** START, 0x7A → 9th bit is NACK (SDA released). No strobes, `busy` stays 0, and the slave remains silent through STOP.
- **Burst write with wrap.** Pointer 0xFFFF, data 0x11, 0x22, 0x33 → writes land at 0xFFFF, 0x0000 and 0x0001.
- **Burst read.** Pointer 0x0010, memory[0x10..0x12] = 0xC3, 0x3C, 0x81. Master ACKs, ACKs, then NACKs → bytes appear in that order and no 4th `reg_rd_en` is issued.
- **Reset mid-transfer.** Assert `rst` during a read byte while SDA is driven low → SDA becomes z within the same cycle and all outputs return to reset values. A following full write transaction completes normally.

Source files
------------

// File: rtl/iic_slave_regs_if.sv
// Register-port bundle between the I2C target and the register file behind it.
// The target drives strobes, pointer and write data; the register side returns read data.
interface iic_slave_regs_if;
  logic        reg_wr_en;
  logic        reg_rd_en;
  logic [15:0] reg_addr;
  logic [7:0]  reg_wdata;
  logic [7:0]  reg_rdata;
  logic        busy;

  modport slave (
    output reg_wr_en,
    output reg_rd_en,
    output reg_addr,
    output reg_wdata,
    output busy,
    input  reg_rdata
  );

  modport master (
    input  reg_wr_en,
    input  reg_rd_en,
    input  reg_addr,
    input  reg_wdata,
    input  busy,
    output reg_rdata
  );
endinterface

// File: rtl/iic_slave_regs.sv
// I2C target with 7-bit device address, 16-bit register pointer and 8-bit data.
// SCL/SDA are oversampled on clk_8m; SDA is only ever pulled low or released.
module iic_slave_regs #(
  parameter logic [6:0] DEV_ADDR = 7'h3C
) (
  input  logic             clk_8m,
  input  logic             rst,
  input  logic             scl,
  inout  wire              sda,
  iic_slave_regs_if.slave  regs
);

  typedef enum logic [3:0] {
    S_IDLE,
    S_ADDR,
    S_IGNORE,
    S_ADDR_ACK,
    S_REG_HI,
    S_ACK_HI,
    S_REG_LO,
    S_ACK_LO,
    S_WR_DATA,
    S_WR_ACK,
    S_RD_DATA,
    S_RD_ACK
  } state_t;

  logic scl_s1_q, scl_s1_d, scl_s2_q, scl_s2_d, scl_dl_q, scl_dl_d;
  logic sda_s1_q, sda_s1_d, sda_s2_q, sda_s2_d, sda_dl_q, sda_dl_d;

  state_t      state_q, state_d;
  logic [7:0]  shift_q, shift_d;
  logic [3:0]  bit_cnt_q, bit_cnt_d;
  logic        rw_q, rw_d;
  logic        sda_oe_q, sda_oe_d;
  logic [15:0] ptr_q, ptr_d;
  logic        wr_en_q, wr_en_d;
  logic        rd_en_q, rd_en_d;
  logic        rd_pend_q, rd_pend_d;
  logic [7:0]  wdata_q, wdata_d;
  logic        busy_q, busy_d;

  logic       scl_rise_s, scl_fall_s, sda_rise_s, sda_fall_s;
  logic       start_s, stop_s;
  logic [7:0] rx_byte_s;
  logic       byte_done_s;

  // Open-drain pad: reset clears sda_oe_q asynchronously, so SDA releases at once.
  assign sda = sda_oe_q ? 1'b0 : 1'bz;

  assign regs.reg_wr_en = wr_en_q;
  assign regs.reg_rd_en = rd_en_q;
  assign regs.reg_addr  = ptr_q;
  assign regs.reg_wdata = wdata_q;
  assign regs.busy      = busy_q;

  assign scl_rise_s  = scl_s2_q & ~scl_dl_q;
  assign scl_fall_s  = ~scl_s2_q & scl_dl_q;
  assign sda_rise_s  = sda_s2_q & ~sda_dl_q;
  assign sda_fall_s  = ~sda_s2_q & sda_dl_q;
  assign start_s     = sda_fall_s & scl_s2_q;
  assign stop_s      = sda_rise_s & scl_s2_q;
  assign rx_byte_s   = {shift_q[6:0], sda_s2_q};
  assign byte_done_s = scl_rise_s & (bit_cnt_q == 4'd7);

  // Next values for the two-stage synchronizers and their edge registers.
  always_comb begin
    scl_s1_d = scl;
    scl_s2_d = scl_s1_q;
    scl_dl_d = scl_s2_q;
    sda_s1_d = sda;
    sda_s2_d = sda_s1_q;
    sda_dl_d = sda_s2_q;
  end

  // Synchronizer and edge-detect registers; reset high to match an idle bus.
  always_ff @(posedge clk_8m or posedge rst) begin
    if (rst) begin
      scl_s1_q <= 1'b1;
      scl_s2_q <= 1'b1;
      scl_dl_q <= 1'b1;
      sda_s1_q <= 1'b1;
      sda_s2_q <= 1'b1;
      sda_dl_q <= 1'b1;
    end else begin
      scl_s1_q <= scl_s1_d;
      scl_s2_q <= scl_s2_d;
      scl_dl_q <= scl_dl_d;
      sda_s1_q <= sda_s1_d;
      sda_s2_q <= sda_s2_d;
      sda_dl_q <= sda_dl_d;
    end
  end

  // Protocol state machine: next state, shift/count, pointer, SDA drive and strobes.
  always_comb begin
    state_d   = state_q;
    shift_d   = shift_q;
    bit_cnt_d = bit_cnt_q;
    rw_d      = rw_q;
    sda_oe_d  = sda_oe_q;
    ptr_d     = ptr_q;
    wr_en_d   = 1'b0;
    rd_en_d   = 1'b0;
    rd_pend_d = rd_en_q;
    wdata_d   = wdata_q;
    busy_d    = busy_q;

    if (start_s) begin
      state_d   = S_ADDR;
      bit_cnt_d = 4'd0;
      sda_oe_d  = 1'b0;
      busy_d    = 1'b0;
      rd_pend_d = 1'b0;
    end else if (stop_s) begin
      state_d   = S_IDLE;
      bit_cnt_d = 4'd0;
      sda_oe_d  = 1'b0;
      busy_d    = 1'b0;
      rd_pend_d = 1'b0;
    end else begin
      case (state_q)
        S_IDLE, S_IGNORE: begin
          sda_oe_d = 1'b0;
        end

        S_ADDR, S_REG_HI, S_REG_LO, S_WR_DATA: begin
          if (scl_rise_s) begin
            shift_d   = rx_byte_s;
            bit_cnt_d = bit_cnt_q + 4'd1;
          end else begin
            shift_d = shift_q;
          end
          if (byte_done_s) begin
            bit_cnt_d = 4'd0;
            case (state_q)
              S_ADDR: begin
                if (rx_byte_s[7:1] == DEV_ADDR) begin
                  rw_d    = rx_byte_s[0];
                  busy_d  = 1'b1;
                  state_d = S_ADDR_ACK;
                end else begin
                  state_d = S_IGNORE;
                end
              end
              S_REG_HI: begin
                ptr_d[15:8] = rx_byte_s;
                state_d     = S_ACK_HI;
              end
              S_REG_LO: begin
                ptr_d[7:0] = rx_byte_s;
                state_d    = S_ACK_LO;
              end
              default: begin
                wr_en_d = 1'b1;
                wdata_d = rx_byte_s;
                state_d = S_WR_ACK;
              end
            endcase
          end else begin
            state_d = state_q;
          end
        end

        // First SCL fall after the 8th bit pulls SDA low; the next one releases it.
        S_ADDR_ACK, S_ACK_HI, S_ACK_LO, S_WR_ACK: begin
          if (scl_fall_s) begin
            if (!sda_oe_q) begin
              sda_oe_d = 1'b1;
            end else begin
              sda_oe_d  = 1'b0;
              bit_cnt_d = 4'd0;
              case (state_q)
                S_ADDR_ACK: begin
                  if (rw_q) begin
                    rd_en_d = 1'b1;
                    state_d = S_RD_DATA;
                  end else begin
                    state_d = S_REG_HI;
                  end
                end
                S_ACK_HI: state_d = S_REG_LO;
                S_ACK_LO: state_d = S_WR_DATA;
                default: begin
                  ptr_d   = ptr_q + 16'd1;
                  state_d = S_WR_DATA;
                end
              endcase
            end
          end else begin
            sda_oe_d = sda_oe_q;
          end
        end

        // Byte arrives from the register port one cycle after the read strobe.
        S_RD_DATA: begin
          if (rd_pend_q) begin
            shift_d   = regs.reg_rdata;
            sda_oe_d  = ~regs.reg_rdata[7];
            bit_cnt_d = 4'd0;
          end else if (scl_rise_s) begin
            bit_cnt_d = bit_cnt_q + 4'd1;
          end else if (scl_fall_s) begin
            if (bit_cnt_q == 4'd8) begin
              sda_oe_d  = 1'b0;
              bit_cnt_d = 4'd0;
              state_d   = S_RD_ACK;
            end else begin
              shift_d  = {shift_q[6:0], shift_q[7]};
              sda_oe_d = ~shift_q[6];
            end
          end else begin
            shift_d = shift_q;
          end
        end

        S_RD_ACK: begin
          sda_oe_d = 1'b0;
          if (scl_rise_s) begin
            if (sda_s2_q) begin
              state_d = S_IGNORE;
            end else begin
              bit_cnt_d = 4'd1;
            end
          end else if (scl_fall_s && (bit_cnt_q == 4'd1)) begin
            ptr_d     = ptr_q + 16'd1;
            rd_en_d   = 1'b1;
            bit_cnt_d = 4'd0;
            state_d   = S_RD_DATA;
          end else begin
            state_d = state_q;
          end
        end

        default: begin
          state_d  = S_IDLE;
          sda_oe_d = 1'b0;
        end
      endcase
    end
  end

  // Protocol registers.
  always_ff @(posedge clk_8m or posedge rst) begin
    if (rst) begin
      state_q   <= S_IDLE;
      shift_q   <= 8'h00;
      bit_cnt_q <= 4'd0;
      rw_q      <= 1'b0;
      sda_oe_q  <= 1'b0;
      ptr_q     <= 16'h0000;
      wr_en_q   <= 1'b0;
      rd_en_q   <= 1'b0;
      rd_pend_q <= 1'b0;
      wdata_q   <= 8'h00;
      busy_q    <= 1'b0;
    end else begin
      state_q   <= state_d;
      shift_q   <= shift_d;
      bit_cnt_q <= bit_cnt_d;
      rw_q      <= rw_d;
      sda_oe_q  <= sda_oe_d;
      ptr_q     <= ptr_d;
      wr_en_q   <= wr_en_d;
      rd_en_q   <= rd_en_d;
      rd_pend_q <= rd_pend_d;
      wdata_q   <= wdata_d;
      busy_q    <= busy_d;
    end
  end

endmodule

// File: tb/tb_iic_slave_regs.sv
// Directed bench for iic_slave_regs: a bit-banged I2C master, a register-file
// model behind the register port, a table of single-byte writes and hand sequences.
module tb_iic_slave_regs;
  localparam int HALF = 16;

  logic clk_8m = 1'b0;
  logic rst;
  logic scl;
  logic m_sda;
  wire  sda;

  assign sda = m_sda ? 1'bz : 1'b0;
  pullup (sda);

  iic_slave_regs_if regs ();

  iic_slave_regs #(.DEV_ADDR(7'h3C)) dut (
    .clk_8m (clk_8m),
    .rst    (rst),
    .scl    (scl),
    .sda    (sda),
    .regs   (regs)
  );

  always #5 clk_8m = ~clk_8m;

  logic [7:0]  mem [0:65535];
  int          wr_cnt = 0;
  int          rd_cnt = 0;
  logic [15:0] wr_addr_log [0:63];
  logic [7:0]  wr_data_log [0:63];
  logic [15:0] rd_addr_log [0:63];
  int          n_tests = 0;
  int          n_fail  = 0;

  // Register-file model: registered read data, logs of every strobe.
  always @(posedge clk_8m) begin
    if (regs.reg_wr_en) begin
      wr_addr_log[wr_cnt[5:0]] <= regs.reg_addr;
      wr_data_log[wr_cnt[5:0]] <= regs.reg_wdata;
      wr_cnt <= wr_cnt + 1;
    end
    if (regs.reg_rd_en) begin
      regs.reg_rdata <= mem[regs.reg_addr];
      rd_addr_log[rd_cnt[5:0]] <= regs.reg_addr;
      rd_cnt <= rd_cnt + 1;
    end
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic tick(input int n);
    repeat (n) @(posedge clk_8m);
    #1;
  endtask

  task automatic bit_xfer(input logic b, output logic r);
    tick(4);
    m_sda = b;
    tick(HALF - 4);
    scl = 1'b1;
    tick(HALF / 2);
    r = sda;
    tick(HALF / 2);
    scl = 1'b0;
  endtask

  task automatic i2c_start();
    tick(4);
    m_sda = 1'b1;
    tick(HALF - 4);
    scl = 1'b1;
    tick(HALF);
    m_sda = 1'b0;
    tick(HALF);
    scl = 1'b0;
  endtask

  task automatic i2c_stop();
    tick(4);
    m_sda = 1'b0;
    tick(HALF - 4);
    scl = 1'b1;
    tick(HALF);
    m_sda = 1'b1;
    tick(HALF);
  endtask

  task automatic wr_byte(input logic [7:0] d, output logic ack);
    logic r;
    for (int i = 7; i >= 0; i--) bit_xfer(d[i], r);
    bit_xfer(1'b1, ack);
  endtask

  task automatic rd_byte(input logic nack, output logic [7:0] d);
    logic r;
    for (int i = 7; i >= 0; i--) begin
      bit_xfer(1'b1, r);
      d[i] = r;
    end
    bit_xfer(nack, r);
  endtask

  typedef struct {
    logic [7:0]  dev;
    logic [15:0] ptr;
    logic [7:0]  data;
    logic        exp_ack;
    logic        exp_busy;
    int          exp_wr;
    logic [15:0] exp_addr;
    logic [7:0]  exp_wdata;
  } wvec_t;

  wvec_t vecs [6];

  initial begin
    logic       a;
    logic [7:0] d;
    int         w0;
    int         r0;

    for (int i = 0; i < 65536; i++) mem[i] = 8'h00;
    rst   = 1'b1;
    scl   = 1'b1;
    m_sda = 1'b1;
    tick(5);
    chk("rst_sda",   {31'd0, sda}, 32'd1);
    chk("rst_wr_en", {31'd0, regs.reg_wr_en}, 32'd0);
    chk("rst_rd_en", {31'd0, regs.reg_rd_en}, 32'd0);
    chk("rst_addr",  {16'd0, regs.reg_addr}, 32'h0);
    chk("rst_wdata", {24'd0, regs.reg_wdata}, 32'h0);
    chk("rst_busy",  {31'd0, regs.busy}, 32'd0);
    rst = 1'b0;
    tick(10);

    vecs[0] = '{8'h78, 16'h1234, 8'hA5, 1'b0, 1'b1, 1, 16'h1234, 8'hA5};
    vecs[1] = '{8'h7A, 16'h1234, 8'hA5, 1'b1, 1'b0, 0, 16'h0000, 8'h00};
    vecs[2] = '{8'h78, 16'h0000, 8'h00, 1'b0, 1'b1, 1, 16'h0000, 8'h00};
    vecs[3] = '{8'h78, 16'hABCD, 8'hFF, 1'b0, 1'b1, 1, 16'hABCD, 8'hFF};
    vecs[4] = '{8'hF0, 16'h5555, 8'h0F, 1'b1, 1'b0, 0, 16'h0000, 8'h00};
    vecs[5] = '{8'h78, 16'h8001, 8'h5E, 1'b0, 1'b1, 1, 16'h8001, 8'h5E};

    for (int v = 0; v < 6; v++) begin
      w0 = wr_cnt;
      i2c_start();
      wr_byte(vecs[v].dev, a);
      chk($sformatf("v%0d_dev_ack", v), {31'd0, a}, {31'd0, vecs[v].exp_ack});
      chk($sformatf("v%0d_busy", v), {31'd0, regs.busy}, {31'd0, vecs[v].exp_busy});
      wr_byte(vecs[v].ptr[15:8], a);
      chk($sformatf("v%0d_hi_ack", v), {31'd0, a}, {31'd0, vecs[v].exp_ack});
      wr_byte(vecs[v].ptr[7:0], a);
      chk($sformatf("v%0d_lo_ack", v), {31'd0, a}, {31'd0, vecs[v].exp_ack});
      wr_byte(vecs[v].data, a);
      chk($sformatf("v%0d_data_ack", v), {31'd0, a}, {31'd0, vecs[v].exp_ack});
      i2c_stop();
      tick(4);
      chk($sformatf("v%0d_busy_stop", v), {31'd0, regs.busy}, 32'd0);
      chk($sformatf("v%0d_wr_count", v), wr_cnt - w0, vecs[v].exp_wr);
      if (vecs[v].exp_wr == 1) begin
        chk($sformatf("v%0d_wr_addr", v), {16'd0, wr_addr_log[w0[5:0]]}, {16'd0, vecs[v].exp_addr});
        chk($sformatf("v%0d_wr_data", v), {24'd0, wr_data_log[w0[5:0]]}, {24'd0, vecs[v].exp_wdata});
      end
    end

    // Combined-format random read
    mem[16'h1234] = 8'h5A;
    w0 = wr_cnt;
    r0 = rd_cnt;
    i2c_start();
    wr_byte(8'h78, a);
    wr_byte(8'h12, a);
    wr_byte(8'h34, a);
    i2c_start();
    wr_byte(8'h79, a);
    chk("rr_dev_ack", {31'd0, a}, 32'd0);
    rd_byte(1'b1, d);
    chk("rr_data", {24'd0, d}, 32'h5A);
    i2c_stop();
    tick(4);
    chk("rr_rd_count", rd_cnt - r0, 1);
    chk("rr_rd_addr", {16'd0, rd_addr_log[r0[5:0]]}, 32'h1234);
    chk("rr_wr_count", wr_cnt - w0, 0);

    // Burst write crossing the pointer wrap
    w0 = wr_cnt;
    i2c_start();
    wr_byte(8'h78, a);
    wr_byte(8'hFF, a);
    wr_byte(8'hFF, a);
    wr_byte(8'h11, a);
    wr_byte(8'h22, a);
    wr_byte(8'h33, a);
    chk("bw_last_ack", {31'd0, a}, 32'd0);
    i2c_stop();
    tick(4);
    chk("bw_count", wr_cnt - w0, 3);
    chk("bw_addr0", {16'd0, wr_addr_log[w0[5:0]]}, 32'hFFFF);
    chk("bw_data0", {24'd0, wr_data_log[w0[5:0]]}, 32'h11);
    chk("bw_addr1", {16'd0, wr_addr_log[(w0 + 1) % 64]}, 32'h0000);
    chk("bw_data1", {24'd0, wr_data_log[(w0 + 1) % 64]}, 32'h22);
    chk("bw_addr2", {16'd0, wr_addr_log[(w0 + 2) % 64]}, 32'h0001);
    chk("bw_data2", {24'd0, wr_data_log[(w0 + 2) % 64]}, 32'h33);

    // Burst read: ACK, ACK, NACK
    mem[16'h0010] = 8'hC3;
    mem[16'h0011] = 8'h3C;
    mem[16'h0012] = 8'h81;
    r0 = rd_cnt;
    i2c_start();
    wr_byte(8'h78, a);
    wr_byte(8'h00, a);
    wr_byte(8'h10, a);
    i2c_start();
    wr_byte(8'h79, a);
    rd_byte(1'b0, d);
    chk("br_byte0", {24'd0, d}, 32'hC3);
    rd_byte(1'b0, d);
    chk("br_byte1", {24'd0, d}, 32'h3C);
    rd_byte(1'b1, d);
    chk("br_byte2", {24'd0, d}, 32'h81);
    i2c_stop();
    tick(20);
    chk("br_rd_count", rd_cnt - r0, 3);
    chk("br_rd_addr0", {16'd0, rd_addr_log[r0[5:0]]}, 32'h0010);
    chk("br_rd_addr1", {16'd0, rd_addr_log[(r0 + 1) % 64]}, 32'h0011);
    chk("br_rd_addr2", {16'd0, rd_addr_log[(r0 + 2) % 64]}, 32'h0012);

    // Reset while the target pulls SDA low for a 0 data bit
    mem[16'h0040] = 8'h00;
    i2c_start();
    wr_byte(8'h78, a);
    wr_byte(8'h00, a);
    wr_byte(8'h40, a);
    i2c_start();
    wr_byte(8'h79, a);
    tick(12);
    chk("mr_sda_driven", {31'd0, sda}, 32'd0);
    rst = 1'b1;
    #1;
    chk("mr_sda_released", {31'd0, sda}, 32'd1);
    chk("mr_busy", {31'd0, regs.busy}, 32'd0);
    chk("mr_addr", {16'd0, regs.reg_addr}, 32'h0);
    chk("mr_rd_en", {31'd0, regs.reg_rd_en}, 32'd0);
    tick(3);
    rst = 1'b0;
    rd_byte(1'b1, d);
    chk("mr_silent", {24'd0, d}, 32'hFF);
    i2c_stop();
    w0 = wr_cnt;
    i2c_start();
    wr_byte(8'h78, a);
    chk("mr_post_ack", {31'd0, a}, 32'd0);
    wr_byte(8'h0F, a);
    wr_byte(8'hF0, a);
    wr_byte(8'h6B, a);
    i2c_stop();
    tick(4);
    chk("mr_post_count", wr_cnt - w0, 1);
    chk("mr_post_addr", {16'd0, wr_addr_log[w0[5:0]]}, 32'h0FF0);
    chk("mr_post_data", {24'd0, wr_data_log[w0[5:0]]}, 32'h6B);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule
